// File: rtl/ram_port_arbiter_if.sv
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : Requester and SRAM bus bundle for ram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              load_done;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_din;
    logic              flash_cs;
    logic              flash_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_cs;
    logic              cpu_we;
    logic              cpu_active;
    logic              halt_req;
    logic              halt_ack;
    logic              rdy;
    logic              booted;
    logic              diag_req;
    logic              diag_we;
    logic [ADDR_W-1:0] diag_addr;
    logic [DATA_W-1:0] diag_din;
    logic              diag_ack;
    logic [DATA_W-1:0] diag_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_cs;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter side
    modport slave (
        input  load_done, flash_addr, flash_din, flash_cs, flash_we,
        input  cpu_addr, cpu_din, cpu_cs, cpu_we, cpu_active,
        input  halt_req, diag_req, diag_we, diag_addr, diag_din, ram_dout,
        output halt_ack, rdy, booted, diag_ack, diag_rdata,
        output ram_addr, ram_din, ram_cs, ram_we
    );

    // Requesters plus SRAM side
    modport master (
        output load_done, flash_addr, flash_din, flash_cs, flash_we,
        output cpu_addr, cpu_din, cpu_cs, cpu_we, cpu_active,
        output halt_req, diag_req, diag_we, diag_addr, diag_din, ram_dout,
        input  halt_ack, rdy, booted, diag_ack, diag_rdata,
        input  ram_addr, ram_din, ram_cs, ram_we
    );
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Single SRAM port owner for flash loader, CPU and diagnostics,
//            sequencing boot/run/halt. Optional macro: DIAG_CYCLE_STEAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_port_arbiter #(
    parameter int HALT_SETTLE = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    localparam int SETTLE_W = $clog2(HALT_SETTLE + 1);

    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_RUN       = 2'd1,
        S_HALT_WAIT = 2'd2,
        S_HALTED    = 2'd3
    } state_t;

    state_t              state_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;
    logic                halt_ack_q;
    logic                rdy_q;
    logic                booted_q;
    logic                diag_ack_q;
    logic                ack_rd_q;
    logic [DATA_W-1:0]   diag_rdata_q;
    logic                grant;

    assign settle_d = settle_q + SETTLE_W'(1);

    // A diag access is granted for one cycle; the ack cycle blocks a regrant.
    always_comb begin
        grant = 1'b0;
        if (!diag_ack_q) begin
            if (state_q == S_HALTED) begin
                grant = bus.diag_req && bus.halt_req;
            end
`ifdef DIAG_CYCLE_STEAL_EN
            else if (state_q == S_RUN) begin
                grant = bus.diag_req && !bus.cpu_active && !bus.cpu_cs;
            end
`endif
        end
    end

    always_comb begin
        bus.ram_addr = bus.diag_addr;
        bus.ram_din  = bus.diag_din;
        bus.ram_cs   = 1'b0;
        bus.ram_we   = 1'b0;
        if (grant) begin
            bus.ram_cs = 1'b1;
            bus.ram_we = bus.diag_we;
        end else begin
            case (state_q)
                S_BOOT: begin
                    bus.ram_addr = bus.flash_addr;
                    bus.ram_din  = bus.flash_din;
                    bus.ram_cs   = bus.flash_cs;
                    bus.ram_we   = bus.flash_we;
                end
                S_RUN, S_HALT_WAIT: begin
                    bus.ram_addr = bus.cpu_addr;
                    bus.ram_din  = bus.cpu_din;
                    bus.ram_cs   = bus.cpu_cs;
                    bus.ram_we   = bus.cpu_we;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            settle_q     <= '0;
            halt_ack_q   <= 1'b0;
            rdy_q        <= 1'b0;
            booted_q     <= 1'b0;
            diag_ack_q   <= 1'b0;
            ack_rd_q     <= 1'b0;
            diag_rdata_q <= '0;
        end else begin
            diag_ack_q <= grant;
            ack_rd_q   <= grant && !bus.diag_we;
            if (diag_ack_q && ack_rd_q) begin
                diag_rdata_q <= bus.ram_dout;
            end
            case (state_q)
                S_BOOT: begin
                    if (bus.load_done) begin
                        state_q  <= S_RUN;
                        booted_q <= 1'b1;
                        rdy_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.halt_req) begin
                        state_q  <= S_HALT_WAIT;
                        rdy_q    <= 1'b0;
                        settle_q <= '0;
                    end
                end
                S_HALT_WAIT: begin
                    if (!bus.halt_req) begin
                        state_q  <= S_RUN;
                        rdy_q    <= 1'b1;
                        settle_q <= '0;
                    end else if (bus.cpu_active) begin
                        settle_q <= '0;
                    end else if (settle_d == SETTLE_W'(HALT_SETTLE)) begin
                        state_q    <= S_HALTED;
                        halt_ack_q <= 1'b1;
                        settle_q   <= '0;
                    end else begin
                        settle_q <= settle_d;
                    end
                end
                S_HALTED: begin
                    // An ack showing this cycle still completes; the port is released after it.
                    if (!bus.halt_req) begin
                        state_q    <= S_RUN;
                        halt_ack_q <= 1'b0;
                        rdy_q      <= 1'b1;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    // SRAM read data lands in the ack cycle, so it is forwarded then and held afterwards.
    assign bus.diag_rdata = (diag_ack_q && ack_rd_q) ? bus.ram_dout : diag_rdata_q;
    assign bus.diag_ack   = diag_ack_q;
    assign bus.halt_ack   = halt_ack_q;
    assign bus.rdy        = rdy_q;
    assign bus.booted     = booted_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter with SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_port_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [7:0] exp_q [$];
    logic [7:0] mem [0:65535];
    logic [4:0] pat;

    ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    ram_port_arbiter #(.HALT_SETTLE(2), .ADDR_W(16), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [7:0] obs);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else chk(tag, 32'(obs), 32'(exp_q.pop_front()));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.load_done  = 1'b0;
        bus.flash_addr = '0; bus.flash_din = '0; bus.flash_cs = 1'b0; bus.flash_we = 1'b0;
        bus.cpu_addr   = '0; bus.cpu_din   = '0; bus.cpu_cs   = 1'b0; bus.cpu_we   = 1'b0;
        bus.cpu_active = 1'b0;
        bus.halt_req   = 1'b0;
        bus.diag_req   = 1'b0; bus.diag_we = 1'b0; bus.diag_addr = '0; bus.diag_din = '0;
        tick();
        tick();
        chk("rst_halt_ack",   32'(bus.halt_ack),   32'd0);
        chk("rst_rdy",        32'(bus.rdy),        32'd0);
        chk("rst_booted",     32'(bus.booted),     32'd0);
        chk("rst_diag_ack",   32'(bus.diag_ack),   32'd0);
        chk("rst_diag_rdata", 32'(bus.diag_rdata), 32'd0);
        rst = 1'b0;

        // BOOT: flash owns the port, diag ignored
        bus.flash_addr = 16'h1234; bus.flash_din = 8'h5A; bus.flash_cs = 1'b1; bus.flash_we = 1'b1;
        bus.cpu_addr = 16'h0BAD; bus.cpu_din = 8'h11; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1;
        bus.diag_req = 1'b1; bus.diag_addr = 16'h0777;
        settle();
        chk("boot_ram_addr", 32'(bus.ram_addr), 32'h1234);
        chk("boot_ram_din",  32'(bus.ram_din),  32'h5A);
        chk("boot_ram_cs",   32'(bus.ram_cs),   32'd1);
        chk("boot_ram_we",   32'(bus.ram_we),   32'd1);
        tick();
        chk("boot_diag_ignored", 32'(bus.diag_ack), 32'd0);
        chk("boot_rdy",          32'(bus.rdy),      32'd0);
        chk("boot_booted",       32'(bus.booted),   32'd0);
        bus.flash_cs = 1'b0; bus.flash_we = 1'b0; bus.diag_req = 1'b0;
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
        bus.load_done = 1'b1;
        tick();
        chk("run_booted", 32'(bus.booted), 32'd1);
        chk("run_rdy",    32'(bus.rdy),    32'd1);
        bus.load_done = 1'b0;

        // RUN: CPU read, flash activity ignored
        bus.flash_addr = 16'hFFFF; bus.flash_din = 8'h00; bus.flash_cs = 1'b1; bus.flash_we = 1'b1;
        bus.cpu_addr = 16'h1234; bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_active = 1'b1;
        settle();
        chk("cpu_ram_addr", 32'(bus.ram_addr), 32'h1234);
        chk("cpu_ram_cs",   32'(bus.ram_cs),   32'd1);
        chk("cpu_ram_we",   32'(bus.ram_we),   32'd0);
        exp_q.push_back(8'h5A);
        tick();
        chk_pop("cpu_rd_data", bus.ram_dout);
        chk("cpu_halt_ack",  32'(bus.halt_ack), 32'd0);
        chk("booted_sticky", 32'(bus.booted),   32'd1);
        bus.cpu_cs = 1'b0; bus.cpu_active = 1'b0; bus.flash_cs = 1'b0; bus.flash_we = 1'b0;

        bus.diag_req = 1'b1; bus.diag_we = 1'b0; bus.diag_addr = 16'h1234;
`ifdef DIAG_CYCLE_STEAL_EN
        settle();
        chk("steal_ram_cs", 32'(bus.ram_cs), 32'd1);
        exp_q.push_back(8'h5A);
        tick();
        chk("steal_ack", 32'(bus.diag_ack), 32'd1);
        chk_pop("steal_rdata", bus.diag_rdata);
        chk("steal_rdy", 32'(bus.rdy), 32'd1);
        bus.diag_req = 1'b0;
        tick();
        chk("steal_ack_pulse", 32'(bus.diag_ack), 32'd0);
        bus.diag_req = 1'b1; bus.cpu_cs = 1'b1; bus.cpu_addr = 16'h2000;
        settle();
        chk("steal_cancel_addr", 32'(bus.ram_addr), 32'h2000);
        tick();
        chk("steal_cancel_ack", 32'(bus.diag_ack), 32'd0);
        bus.cpu_cs = 1'b0; bus.diag_req = 1'b0;
`else
        tick();
        tick();
        chk("run_diag_wait_ack", 32'(bus.diag_ack), 32'd0);
        chk("run_diag_wait_cs",  32'(bus.ram_cs),   32'd0);
        bus.diag_req = 1'b0;
`endif

        // Halt handshake with settle pattern 1,0,1,0,0
        bus.halt_req = 1'b1; bus.cpu_active = 1'b1;
        tick();
        chk("hw_rdy",      32'(bus.rdy),      32'd0);
        chk("hw_halt_ack", 32'(bus.halt_ack), 32'd0);
        pat = 5'b00101;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_active = pat[i];
            tick();
            chk($sformatf("settle_%0d", i), 32'(bus.halt_ack), 32'(i == 4));
        end
        bus.cpu_active = 1'b0;

        // HALTED: diag write then read back
        bus.diag_req = 1'b1; bus.diag_we = 1'b1; bus.diag_addr = 16'h0400; bus.diag_din = 8'hA5;
        settle();
        chk("dwr_ram_cs",   32'(bus.ram_cs),   32'd1);
        chk("dwr_ram_we",   32'(bus.ram_we),   32'd1);
        chk("dwr_ram_addr", 32'(bus.ram_addr), 32'h0400);
        chk("dwr_ram_din",  32'(bus.ram_din),  32'hA5);
        tick();
        chk("dwr_ack",      32'(bus.diag_ack), 32'd1);
        chk("dwr_no_regrant", 32'(bus.ram_cs), 32'd0);
        bus.diag_req = 1'b0;
        tick();
        chk("dwr_ack_pulse", 32'(bus.diag_ack), 32'd0);
        bus.diag_req = 1'b1; bus.diag_we = 1'b0;
        settle();
        chk("drd_ram_cs", 32'(bus.ram_cs), 32'd1);
        chk("drd_ram_we", 32'(bus.ram_we), 32'd0);
        exp_q.push_back(8'hA5);
        tick();
        chk("drd_ack", 32'(bus.diag_ack), 32'd1);
        chk_pop("drd_rdata", bus.diag_rdata);
        bus.diag_req = 1'b0;
        tick();
        chk("drd_ack_pulse", 32'(bus.diag_ack),   32'd0);
        chk("drd_rdata_hold", 32'(bus.diag_rdata), 32'hA5);

        // Release halt while a read is in flight
        bus.diag_req = 1'b1; bus.diag_addr = 16'h1234;
        exp_q.push_back(8'h5A);
        tick();
        bus.halt_req = 1'b0; bus.diag_req = 1'b0;
        settle();
        chk("rel_ack",      32'(bus.diag_ack), 32'd1);
        chk_pop("rel_rdata", bus.diag_rdata);
        chk("rel_halt_ack", 32'(bus.halt_ack), 32'd1);
        chk("rel_rdy",      32'(bus.rdy),      32'd0);
        tick();
        chk("run2_rdy",      32'(bus.rdy),      32'd1);
        chk("run2_halt_ack", 32'(bus.halt_ack), 32'd0);
        chk("run2_diag_ack", 32'(bus.diag_ack), 32'd0);

        // Re-halt, then reset from HALTED
        bus.halt_req = 1'b1;
        tick();
        tick();
        tick();
        chk("rehalt_ack", 32'(bus.halt_ack), 32'd1);
        rst = 1'b1;
        bus.flash_addr = 16'h0ABC; bus.flash_cs = 1'b1; bus.flash_we = 1'b0;
        tick();
        chk("mrst_rdy",      32'(bus.rdy),      32'd0);
        chk("mrst_halt_ack", 32'(bus.halt_ack), 32'd0);
        chk("mrst_booted",   32'(bus.booted),   32'd0);
        rst = 1'b0;
        settle();
        chk("mrst_ram_addr", 32'(bus.ram_addr), 32'h0ABC);
        chk("mrst_ram_cs",   32'(bus.ram_cs),   32'd1);
        chk("mrst_ram_we",   32'(bus.ram_we),   32'd0);
        chk("sb_drained",    32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
